// File: rtl/usb_desc_streamer_pkg.sv
// Shared constants and FSM state encoding for the EP0 GET_DESCRIPTOR data-stage engine.
package usb_desc_pkg;

    localparam logic [7:0] DT_DEVICE      = 8'd1;
    localparam logic [7:0] DT_CONFIG      = 8'd2;
    localparam logic [7:0] DT_STRING      = 8'd3;
    localparam logic [7:0] DT_QUALIFIER   = 8'd6;
    localparam logic [7:0] DT_OTHER_SPEED = 8'd7;

    localparam int unsigned EP0_MAXPKT = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SEND,
        S_WAIT_ACK,
        S_ZLP,
        S_ZWAIT,
        S_DONE,
        S_STALL
    } state_t;

endpackage

// File: rtl/usb_desc_streamer_if.sv
// Packet transmitter handshake between the descriptor streamer (master) and the transmitter (slave).
interface usb_desc_streamer_if;
    import usb_desc_pkg::*;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_zlp;
    logic       tx_ready;
    logic       pkt_ack;
    logic       pkt_retry;

    modport master (
        output tx_valid, tx_data, tx_last, tx_zlp,
        input  tx_ready, pkt_ack, pkt_retry
    );

    modport slave (
        input  tx_valid, tx_data, tx_last, tx_zlp,
        output tx_ready, pkt_ack, pkt_retry
    );

endinterface

// File: rtl/usb_desc_streamer_lookup.sv
// Combinational map from (descriptor type, index, link speed) to ROM base address and length.
module usb_desc_lookup
    import usb_desc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [7:0]        dtype,
    input  logic [7:0]        dindex,
    input  logic              hs_mode,
    input  logic              have_strings,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [ADDR_W-1:0] qual_addr,
    input  logic [ADDR_W-1:0] fscfg_addr,
    input  logic [ADDR_W-1:0] hscfg_addr,
    input  logic [ADDR_W-1:0] strlang_addr,
    input  logic [ADDR_W-1:0] strvendor_addr,
    input  logic [ADDR_W-1:0] strproduct_addr,
    input  logic [ADDR_W-1:0] strserial_addr,
    input  logic [15:0]       dev_len,
    input  logic [15:0]       qual_len,
    input  logic [15:0]       fscfg_len,
    input  logic [15:0]       hscfg_len,
    input  logic [15:0]       strvendor_len,
    input  logic [15:0]       strproduct_len,
    input  logic [15:0]       strserial_len,
    output logic [ADDR_W-1:0] base,
    output logic [15:0]       len,
    output logic              supported,
    output logic              patch_en
);

    always_comb begin
        base      = '0;
        len       = '0;
        supported = 1'b0;
        patch_en  = 1'b0;
        case (dtype)
            DT_DEVICE: begin
                base = dev_addr;   len = dev_len;   supported = 1'b1;
            end
            DT_CONFIG: begin
                base = hs_mode ? hscfg_addr : fscfg_addr;
                len  = hs_mode ? hscfg_len  : fscfg_len;
                supported = 1'b1;
            end
            DT_QUALIFIER: begin
                base = qual_addr;  len = qual_len;  supported = 1'b1;
            end
            // Other-speed config is the config for the speed we are not running at
            DT_OTHER_SPEED: begin
                base = hs_mode ? fscfg_addr : hscfg_addr;
                len  = hs_mode ? fscfg_len  : hscfg_len;
                supported = 1'b1;
                patch_en  = 1'b1;
            end
            DT_STRING: begin
                if (have_strings) begin
                    supported = 1'b1;
                    case (dindex)
                        8'd0:    begin base = strlang_addr;    len = 16'd4;          end
                        8'd1:    begin base = strvendor_addr;  len = strvendor_len;  end
                        8'd2:    begin base = strproduct_addr; len = strproduct_len; end
                        8'd3:    begin base = strserial_addr;  len = strserial_len;  end
                        default: supported = 1'b0;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/usb_desc_streamer.sv
// EP0 control-IN data stage: resolves a GET_DESCRIPTOR request and streams the ROM contents
// as MAXPKT-sized packets with host ACK/retry, trailing ZLP and STALL for unsupported requests.
module usb_desc_streamer
    import usb_desc_pkg::*;
#(
    parameter int unsigned MAXPKT = EP0_MAXPKT,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req_valid,
    input  logic [15:0]       i_wvalue,
    input  logic [15:0]       i_wlength,
    input  logic              i_hs_mode,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_desc_dev_addr,
    input  logic [ADDR_W-1:0] i_desc_qual_addr,
    input  logic [ADDR_W-1:0] i_desc_fscfg_addr,
    input  logic [ADDR_W-1:0] i_desc_hscfg_addr,
    input  logic [ADDR_W-1:0] i_desc_oscfg_addr,
    input  logic [ADDR_W-1:0] i_desc_strlang_addr,
    input  logic [ADDR_W-1:0] i_desc_strvendor_addr,
    input  logic [ADDR_W-1:0] i_desc_strproduct_addr,
    input  logic [ADDR_W-1:0] i_desc_strserial_addr,
    input  logic [15:0]       i_desc_dev_len,
    input  logic [15:0]       i_desc_qual_len,
    input  logic [15:0]       i_desc_fscfg_len,
    input  logic [15:0]       i_desc_hscfg_len,
    input  logic [15:0]       i_desc_strvendor_len,
    input  logic [15:0]       i_desc_strproduct_len,
    input  logic [15:0]       i_desc_strserial_len,
    input  logic              i_have_strings,
    output logic [ADDR_W-1:0] o_descrom_raddr,
    input  logic [7:0]        i_descrom_rdat,
    usb_desc_streamer_if.master tx,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned PKT_LSB  = $clog2(MAXPKT);
    localparam logic [15:0] MAXPKT_W = 16'(MAXPKT);

    state_t            state, state_n;
    logic [15:0]       wvalue_q, wlength_q, xfer_len_q, offset_q, pkt_start_q;
    logic              hs_q, patch_en_q;
    logic [7:0]        patch_q;
    logic [ADDR_W-1:0] base_q, raddr_q;

    logic [ADDR_W-1:0] lk_base;
    logic [15:0]       lk_len, lk_xfer, off_inc, pkt_bytes;
    logic              lk_sup, lk_patch, start, last_byte, zlp_need;

    usb_desc_lookup #(.ADDR_W(ADDR_W)) u_lookup (
        .dtype(wvalue_q[15:8]),                 .dindex(wvalue_q[7:0]),
        .hs_mode(hs_q),                         .have_strings(i_have_strings),
        .dev_addr(i_desc_dev_addr),             .qual_addr(i_desc_qual_addr),
        .fscfg_addr(i_desc_fscfg_addr),         .hscfg_addr(i_desc_hscfg_addr),
        .strlang_addr(i_desc_strlang_addr),     .strvendor_addr(i_desc_strvendor_addr),
        .strproduct_addr(i_desc_strproduct_addr), .strserial_addr(i_desc_strserial_addr),
        .dev_len(i_desc_dev_len),               .qual_len(i_desc_qual_len),
        .fscfg_len(i_desc_fscfg_len),           .hscfg_len(i_desc_hscfg_len),
        .strvendor_len(i_desc_strvendor_len),   .strproduct_len(i_desc_strproduct_len),
        .strserial_len(i_desc_strserial_len),
        .base(lk_base), .len(lk_len), .supported(lk_sup), .patch_en(lk_patch)
    );

    assign lk_xfer   = (lk_len < wlength_q) ? lk_len : wlength_q;
    assign off_inc   = offset_q + 16'd1;
    assign pkt_bytes = off_inc - pkt_start_q;
    assign last_byte = (off_inc == xfer_len_q) || (pkt_bytes == MAXPKT_W);
    assign zlp_need  = (xfer_len_q < wlength_q) && (xfer_len_q[PKT_LSB-1:0] == '0);
    // An abort in the same cycle lets a new request in even while busy
    assign start     = i_req_valid &&
                       (i_abort || state == S_IDLE || state == S_DONE || state == S_STALL);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_LOOKUP:   state_n = !lk_sup ? S_STALL : (lk_xfer == '0) ? S_DONE : S_SEND;
            S_SEND:     if (tx.tx_ready && last_byte) state_n = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx.pkt_retry)                  state_n = S_SEND;
                else if (tx.pkt_ack)
                    state_n = (offset_q < xfer_len_q) ? S_SEND : zlp_need ? S_ZLP : S_DONE;
            end
            S_ZLP:      state_n = S_ZWAIT;
            S_ZWAIT: begin
                if (tx.pkt_retry)    state_n = S_ZLP;
                else if (tx.pkt_ack) state_n = S_DONE;
            end
            S_DONE:     state_n = S_IDLE;
            default:    ;
        endcase
        if (i_abort) state_n = S_IDLE;
        if (start)   state_n = S_LOOKUP;
    end

    // raddr is pre-loaded one cycle ahead: oscfg for the patch fetch, then base + next offset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wvalue_q <= '0; wlength_q <= '0; hs_q <= 1'b0;
            base_q <= '0; xfer_len_q <= '0; offset_q <= '0; pkt_start_q <= '0;
            patch_en_q <= 1'b0; patch_q <= '0; raddr_q <= '0;
        end else if (start) begin
            wvalue_q  <= i_wvalue;
            wlength_q <= i_wlength;
            hs_q      <= i_hs_mode;
            raddr_q   <= i_desc_oscfg_addr;
        end else if (!i_abort) begin
            case (state)
                S_LOOKUP: begin
                    base_q      <= lk_base;
                    xfer_len_q  <= lk_xfer;
                    patch_en_q  <= lk_patch;
                    patch_q     <= i_descrom_rdat;
                    offset_q    <= '0;
                    pkt_start_q <= '0;
                    raddr_q     <= lk_base;
                end
                S_SEND: if (tx.tx_ready) begin
                    offset_q <= off_inc;
                    raddr_q  <= base_q + ADDR_W'(off_inc);
                end
                S_WAIT_ACK: begin
                    if (tx.pkt_retry) begin
                        offset_q <= pkt_start_q;
                        raddr_q  <= base_q + ADDR_W'(pkt_start_q);
                    end else if (tx.pkt_ack) begin
                        pkt_start_q <= offset_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx.tx_valid     = (state == S_SEND);
        tx.tx_last      = (state == S_SEND) && last_byte;
        tx.tx_zlp       = (state == S_ZLP);
        tx.tx_data      = '0;
        if (state == S_SEND)
            tx.tx_data  = (patch_en_q && offset_q == 16'd1) ? patch_q : i_descrom_rdat;
        o_descrom_raddr = raddr_q;
        o_stall         = (state == S_STALL);
        o_busy          = (state == S_LOOKUP) || (state == S_SEND) || (state == S_WAIT_ACK) ||
                          (state == S_ZLP) || (state == S_ZWAIT);
        o_done          = (state == S_DONE);
    end

endmodule
